// File: rtl/register_file_pkg.sv
// Shared constants and word type for the register file slice.
package register_file_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int MASK_W_DEF = DATA_W_DEF / 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/register_file_reg_word.sv
// One register word: async active-low clear, byte-masked load.
module reg_word #(
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [MASK_W-1:0] mask,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (mask[k]) q[8*k +: 8] <= d[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// 32-entry, two-read one-write register file with byte masks and forwarding.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic [MASK_W-1:0] W_MASK,
    input  logic [ADDR_W-1:0] R_ADDR1,
    input  logic [ADDR_W-1:0] R_ADDR2,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] lane_bits;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              fwd1;
    logic              fwd2;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        reg_word #(
            .DATA_W (DATA_W),
            .MASK_W (MASK_W)
        ) u_word (
            .clk   (CLK),
            .rst_n (RST),
            .we    (RegWrite && (W_ADDR == ADDR_W'(i))),
            .mask  (W_MASK),
            .d     (W_DATA),
            .q     (regs[i])
        );
    end

    always_comb begin
        lane_bits = '0;
        for (int k = 0; k < MASK_W; k++) begin
            lane_bits[8*k +: 8] = {8{W_MASK[k]}};
        end
    end

    assign rd1  = regs[R_ADDR1];
    assign rd2  = regs[R_ADDR2];
    assign fwd1 = RegWrite && (R_ADDR1 == W_ADDR);
    assign fwd2 = RegWrite && (R_ADDR2 == W_ADDR);

    // Forwarded value is the stored word with the enabled lanes replaced.
    always_comb begin
        OUT1 = '0;
        OUT2 = '0;
        if (RST) begin
            OUT1 = fwd1 ? ((rd1 & ~lane_bits) | (W_DATA & lane_bits)) : rd1;
            OUT2 = fwd2 ? ((rd2 & ~lane_bits) | (W_DATA & lane_bits)) : rd2;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file.
module tb_register_file;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RegWrite;
    logic [4:0]  W_ADDR;
    logic [63:0] W_DATA;
    logic [7:0]  W_MASK;
    logic [4:0]  R_ADDR1;
    logic [4:0]  R_ADDR2;
    logic [63:0] OUT1;
    logic [63:0] OUT2;

    typedef struct {
        string       tag;
        bit          port;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] mdl [32];
    int          n_cmp = 0;
    int          n_err = 0;

    register_file dut (
        .CLK      (CLK),
        .RST      (RST),
        .RegWrite (RegWrite),
        .W_ADDR   (W_ADDR),
        .W_DATA   (W_DATA),
        .W_MASK   (W_MASK),
        .R_ADDR1  (R_ADDR1),
        .R_ADDR2  (R_ADDR2),
        .OUT1     (OUT1),
        .OUT2     (OUT2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] d,
                                          input logic [7:0]  m);
        logic [63:0] r;
        r = old;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    task automatic push(input string tag, input bit port,
                        input logic [63:0] exp);
        sb_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, e.port ? OUT2 : OUT1, e.exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [63:0] e1,
                      input logic [63:0] e2);
        R_ADDR1 = a1;
        R_ADDR2 = a2;
        push({tag, "_p1"}, 1'b0, e1);
        push({tag, "_p2"}, 1'b1, e2);
        drain();
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d,
                      input logic [7:0] m);
        @(negedge CLK);
        RegWrite = 1'b1;
        W_ADDR   = a;
        W_DATA   = d;
        W_MASK   = m;
        @(negedge CLK);
        RegWrite = 1'b0;
        if (RST) mdl[a] = merge(mdl[a], d, m);
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd(tag, 5'(i), 5'(31 - i), mdl[i], mdl[31 - i]);
        end
    endtask

    initial begin
        RST      = 1'b0;
        RegWrite = 1'b0;
        W_ADDR   = '0;
        W_DATA   = '0;
        W_MASK   = '0;
        R_ADDR1  = '0;
        R_ADDR2  = '0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        repeat (2) @(negedge CLK);
        rd_all("reset");
        RST = 1'b1;

        for (int i = 0; i < 32; i++) wr(5'(i), 64'(i) + 64'h10000, 8'hFF);
        rd_all("sweep");
        rd("addr0", 5'd0, 5'd0, 64'h10000, 64'h10000);

        @(negedge CLK);
        RegWrite = 1'b1;
        W_ADDR   = 5'd5;
        W_DATA   = 64'd25;
        W_MASK   = 8'hFF;
        rd("fwd", 5'd5, 5'd5, 64'd25, 64'd25);
        rd("fwd_other", 5'd4, 5'd5, 64'h10004, 64'd25);
        @(negedge CLK);
        RegWrite = 1'b0;
        mdl[5] = 64'd25;
        rd("post_fwd", 5'd4, 5'd5, 64'h10004, 64'd25);

        @(negedge CLK);
        RegWrite = 1'b1;
        W_ADDR   = 5'd6;
        W_DATA   = 64'hAABBCCDDEEFF0011;
        W_MASK   = 8'h81;
        rd("fwd_mask", 5'd6, 5'd2, 64'hAA00000000010011, 64'h10002);
        @(negedge CLK);
        RegWrite = 1'b0;
        mdl[6] = merge(mdl[6], 64'hAABBCCDDEEFF0011, 8'h81);
        rd("post_fwd_mask", 5'd2, 5'd6, 64'h10002, 64'hAA00000000010011);

        wr(5'd3, 64'h1111111111111111, 8'hFF);
        wr(5'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        rd("mask", 5'd3, 5'd3, 64'h11111111FFFFFFFF, mdl[3]);
        wr(5'd3, 64'h0, 8'h00);
        rd("mask0", 5'd3, 5'd3, 64'h11111111FFFFFFFF, 64'h11111111FFFFFFFF);

        @(negedge CLK);
        W_ADDR = 5'd3;
        W_DATA = '0;
        W_MASK = 8'hFF;
        @(negedge CLK);
        rd("we0", 5'd3, 5'd3, 64'h11111111FFFFFFFF, 64'h11111111FFFFFFFF);

        wr(5'd9, 64'h0123456789ABCDEF, 8'hFF);
        wr(5'd9, 64'hFFFFFFFFFFFFFF55, 8'h01);
        rd("b2b", 5'd9, 5'd8, 64'h0123456789ABCD55, 64'h10008);

        @(negedge CLK);
        RegWrite = 1'b1;
        W_ADDR   = 5'd12;
        W_DATA   = 64'hDEAD;
        W_MASK   = 8'hFF;
        #2;
        RST = 1'b0;
        rd("arst", 5'd12, 5'd9, 64'h0, 64'h0);
        @(negedge CLK);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rd_all("arst_all");
        @(negedge CLK);
        RST = 1'b1;
        rd("arst_rel", 5'd12, 5'd3, 64'h0, 64'h0);
        wr(5'd7, 64'hABCD, 8'hFF);
        rd_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning register width in bits (must be a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth is 2**ADDR_W = 32 registers.
REQ-003 The block SHALL have parameter MASK_W, default DATA_W/8 = 8, meaning number of byte lanes.
REQ-004 The block SHALL have port CLK  input  1  the single clock; all writes are on the rising edge.
REQ-005 The block SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port RegWrite  input  1  write enable.
REQ-007 The block SHALL have port W_ADDR  input  ADDR_W  write address.
REQ-008 The block SHALL have port W_DATA  input  DATA_W  write data.
REQ-009 The block SHALL have port W_MASK  input  MASK_W  byte-lane write enables; bit k controls W_DATA[8k+7:8k].
REQ-010 The block SHALL have ports R_ADDR1 and R_ADDR2  input  ADDR_W  read addresses for ports 1 and 2.
REQ-011 The block SHALL have ports OUT1 and OUT2  output  DATA_W  read data for ports 1 and 2.

Function
REQ-012 Storage SHALL be 32 registers of DATA_W bits each; all registers, including address 0, SHALL be writable. There is no hardwired-zero register.
REQ-013 On a rising CLK with RST high and RegWrite=1, each byte lane k of register W_ADDR with W_MASK[k]=1 SHALL take W_DATA lane k; lanes with W_MASK[k]=0 SHALL keep their value.
REQ-014 RegWrite=0 or W_MASK=0 SHALL leave every register unchanged.
REQ-015 OUT1 and OUT2 SHALL be combinational, zero-latency reads of the registers at R_ADDR1 and R_ADDR2.
REQ-016 Both read ports SHALL be independent; equal read addresses SHALL return identical data.
REQ-017 Write forwarding: when RegWrite=1 and R_ADDRn equals W_ADDR, OUTn SHALL show the stored value merged with W_DATA on the enabled lanes, in the same cycle, before the clock edge.
REQ-018 After the write edge, OUTn SHALL show the newly stored value, with no glitch to stale data once inputs are stable.
REQ-019 Writing the same address on consecutive cycles SHALL leave the last write in effect; each cycle's mask applies independently.
REQ-020 No other boundary behaviour applies: addresses span the full range 0..31, so out-of-range access is not possible.

Reset
REQ-021 While RST=0, all 32 registers SHALL be cleared to 0 asynchronously, with no clock required.
REQ-022 While RST=0, writes SHALL be ignored, and OUT1 and OUT2 SHALL read 0, with forwarding suppressed.
REQ-023 If RST is asserted in the middle of an operation, it SHALL override any write in progress; the first write after release takes effect on the first rising CLK edge with RST=1.

Structure
REQ-024 The constants DATA_W, ADDR_W, MASK_W and DEPTH defaults, together with a data-word typedef, SHALL live in the shared package register_file_pkg.
REQ-025 An optional sub-module, reg_word, SHALL hold one DATA_W-bit register with asynchronous active-low clear and byte-masked load. The top level SHALL instantiate it 32 times and add the write decoder, the two read muxes and the forwarding logic.

Verification
REQ-026 Reset scenario: hold RST=0 for 2 cycles, then read all addresses -> OUT1 and OUT2 read 0 for every address.
REQ-027 Sweep scenario: with W_MASK=FF, write address i with value i+0x10000 for i=0..31, then read each address on both ports -> both ports return i+0x10000. Address 0 returns 0x10000, confirming it is writable.
REQ-028 Forwarding scenario: register 5 holds 0x10005; drive RegWrite=1, W_ADDR=5, W_DATA=25, W_MASK=FF, R_ADDR1=R_ADDR2=5 -> OUT1 and OUT2 read 25 in the same cycle, before the edge. After the edge, with RegWrite=0, reading address 4 returns 0x10004 and reading address 5 returns 25.
REQ-029 Mask scenario: register 3 holds 0x1111111111111111; write W_DATA=0xFFFFFFFFFFFFFFFF with W_MASK=0x0F -> register 3 reads 0x11111111FFFFFFFF. A subsequent write with W_MASK=0x00 changes nothing.
REQ-030 Asynchronous reset scenario: after the registers are loaded, assert RST low between clock edges -> all outputs read 0 immediately. Release RST, write 0xABCD to address 7 -> only address 7 reads 0xABCD; all others read 0.
